// File: rtl/cache_pkg.sv
// Shared definitions for the cache miss-fill controller: FSM encoding and
// block geometry.
package cache_pkg;
    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_e;

    localparam int BLOCK_BYTES = 16;
    localparam int WORD_BYTES  = 2;
    localparam int OFFSET_W    = 4;
endpackage

// File: rtl/dff.sv
// Generic D flip-flop cell with asynchronous active-high reset to RST_VAL.
module dff #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= RST_VAL;
        else     q <= d;
    end
endmodule

// File: rtl/fill_counter.sv
// Synchronous up-counter with clear (dominant over enable) and async reset.
module fill_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt_q
);
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)     cnt_d = '0;
        else if (en) cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: stalls the pipeline, issues one read per cycle
// for the whole block and writes returned words, then the tag.
module cache_fill_fsm
    import cache_pkg::*;
#(
    parameter int WORDS_PER_BLOCK = 8,
    parameter int ADDR_W          = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               miss_detected,
    input  logic [ADDR_W-1:0]                  miss_address,
    output logic                               fsm_busy,
    output logic                               write_data_array,
    output logic                               write_tag_array,
    output logic [$clog2(WORDS_PER_BLOCK)-1:0] cache_word_offset,
    output logic [ADDR_W-1:0]                  memory_address,
    output logic                               mem_enable,
    input  logic                               memory_data_valid
);
    localparam int OFF_W = $clog2(WORDS_PER_BLOCK);
    localparam int CNT_W = OFF_W + 1;

    fill_state_e       state_q, state_d;
    logic [0:0]        state_raw_q;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]  req_cnt_q, rcv_cnt_q;
    logic              cnt_clr, req_en, rcv_en, last_rcv;
    logic [OFF_W-1:0]  req_idx;
    logic              unused_low_addr;

    assign unused_low_addr = ^miss_address[OFFSET_W-1:0];

    dff #(.W(1)) u_state_ff (
        .clk(clk), .rst(rst), .d(state_d), .q(state_raw_q)
    );
    assign state_q = fill_state_e'(state_raw_q);

    dff #(.W(ADDR_W)) u_base_ff (
        .clk(clk), .rst(rst), .d(base_d), .q(base_q)
    );

    fill_counter #(.W(CNT_W)) u_req_cnt (
        .clk(clk), .rst(rst), .clr(cnt_clr), .en(req_en), .cnt_q(req_cnt_q)
    );

    fill_counter #(.W(CNT_W)) u_rcv_cnt (
        .clk(clk), .rst(rst), .clr(cnt_clr), .en(rcv_en), .cnt_q(rcv_cnt_q)
    );

    assign last_rcv = (rcv_cnt_q == CNT_W'(WORDS_PER_BLOCK - 1));
    // Once all requests are out the counter parks at WORDS_PER_BLOCK; the
    // address then keeps showing the final word of the block.
    assign req_idx  = req_cnt_q[CNT_W-1] ? '1 : req_cnt_q[OFF_W-1:0];

    always_comb begin
        state_d          = state_q;
        base_d           = base_q;
        cnt_clr          = 1'b0;
        req_en           = 1'b0;
        rcv_en           = 1'b0;
        fsm_busy         = 1'b0;
        mem_enable       = 1'b0;
        write_data_array = 1'b0;
        write_tag_array  = 1'b0;
        unique case (state_q)
            IDLE: begin
                fsm_busy = miss_detected;
                if (miss_detected) begin
                    base_d  = {miss_address[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                    cnt_clr = 1'b1;
                    state_d = FILL;
                end
            end
            FILL: begin
                fsm_busy         = 1'b1;
                mem_enable       = ~req_cnt_q[CNT_W-1];
                req_en           = ~req_cnt_q[CNT_W-1];
                rcv_en           = memory_data_valid;
                write_data_array = memory_data_valid;
                write_tag_array  = memory_data_valid & last_rcv;
                if (memory_data_valid && last_rcv) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign memory_address    = base_q + ADDR_W'(req_idx) * ADDR_W'(WORD_BYTES);
    assign cache_word_offset = rcv_cnt_q[OFF_W-1:0];
endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm: fixed and gapped memory latencies, address
// wrap, ignored mid-fill misses, back-to-back misses, reset mid-fill, idle valids.
module tb_cache_fill_fsm;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        miss_detected = 1'b0;
    logic [15:0] miss_address = '0;
    logic        memory_data_valid = 1'b0;
    logic        fsm_busy, write_data_array, write_tag_array, mem_enable;
    logic [2:0]  cache_word_offset;
    logic [15:0] memory_address;

    int ncmp = 0;
    int nfail = 0;

    cache_fill_fsm #(.WORDS_PER_BLOCK(8), .ADDR_W(16)) dut (
        .clk(clk), .rst(rst),
        .miss_detected(miss_detected), .miss_address(miss_address),
        .fsm_busy(fsm_busy), .write_data_array(write_data_array),
        .write_tag_array(write_tag_array), .cache_word_offset(cache_word_offset),
        .memory_address(memory_address), .mem_enable(mem_enable),
        .memory_data_valid(memory_data_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs are applied just after a rising edge; outputs are sampled 2ns later.
    task automatic drive(input logic miss, input logic [15:0] addr, input logic vld);
        miss_detected     = miss;
        miss_address      = addr;
        memory_data_valid = vld;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag, input logic [15:0] addr_exp);
        chk({tag, "_busy"}, 16'(fsm_busy), 16'd0);
        chk({tag, "_men"},  16'(mem_enable), 16'd0);
        chk({tag, "_wd"},   16'(write_data_array), 16'd0);
        chk({tag, "_wt"},   16'(write_tag_array), 16'd0);
        chk({tag, "_addr"}, memory_address, addr_exp);
    endtask

    // Call in cycle 1 of a fill. The k-th valid arrives in cycle 1+lat+k*gap.
    // With inj set, a stray miss to 0x4000 is presented in cycles 2..4.
    task automatic run_fill(input string tag, input logic [15:0] base,
                            input int lat, input int gap, input bit inj);
        int last;
        last = 1 + lat + 7 * gap;
        for (int c = 1; c <= last; c++) begin
            logic v;
            int   k;
            v = (c >= 1 + lat) && (((c - 1 - lat) % gap) == 0);
            k = (c - 1 - lat) / gap;
            drive(inj && c >= 2 && c <= 4, 16'h4000, v);
            chk({tag, "_busy"}, 16'(fsm_busy), 16'd1);
            chk({tag, "_men"},  16'(mem_enable), 16'(c <= 8));
            chk({tag, "_addr"}, memory_address,
                (c <= 8) ? base + 16'(2 * (c - 1)) : base + 16'd14);
            chk({tag, "_wd"},   16'(write_data_array), 16'(v));
            if (v) chk({tag, "_off"}, 16'(cache_word_offset), 16'(k));
            chk({tag, "_wt"},   16'(write_tag_array), 16'(c == last));
            tick();
        end
    endtask

    initial begin
        // Reset state
        #2;
        chk_idle("rst", 16'h0000);
        chk("rst_off", 16'(cache_word_offset), 16'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Miss at 0x1236, latency 4: busy cycles 0..12, tag in cycle 12
        drive(1'b1, 16'h1236, 1'b0);
        chk("m0_busy", 16'(fsm_busy), 16'd1);
        chk("m0_men",  16'(mem_enable), 16'd0);
        tick();
        run_fill("l4", 16'h1230, 4, 1, 1'b0);
        drive(1'b0, 16'h0000, 1'b0);
        chk_idle("l4_end", 16'h123E);

        // Top-of-memory block, no wrap past 0xFFFE
        tick();
        drive(1'b1, 16'hFFFA, 1'b0);
        chk("wrap_m_busy", 16'(fsm_busy), 16'd1);
        tick();
        run_fill("wrap", 16'hFFF0, 1, 1, 1'b0);
        drive(1'b0, 16'h0000, 1'b0);
        chk_idle("wrap_end", 16'hFFFE);

        // Valids every other cycle
        tick();
        drive(1'b1, 16'h0104, 1'b0);
        tick();
        run_fill("gap", 16'h0100, 1, 2, 1'b0);
        drive(1'b0, 16'h0000, 1'b0);
        chk_idle("gap_end", 16'h010E);

        // Stray miss mid-fill ignored; miss in the release cycle starts next fill
        tick();
        drive(1'b1, 16'h2000, 1'b0);
        tick();
        run_fill("ign", 16'h2000, 2, 1, 1'b1);
        drive(1'b1, 16'h4000, 1'b0);
        chk("b2b_busy", 16'(fsm_busy), 16'd1);
        chk("b2b_men",  16'(mem_enable), 16'd0);
        chk("b2b_addr", memory_address, 16'h200E);
        tick();
        run_fill("b2b", 16'h4000, 1, 1, 1'b0);
        drive(1'b0, 16'h0000, 1'b0);
        chk_idle("b2b_end", 16'h400E);

        // Reset after three data writes
        tick();
        drive(1'b1, 16'h5552, 1'b0);
        tick();
        for (int c = 1; c <= 4; c++) begin
            drive(1'b0, 16'h0000, c >= 2);
            if (c >= 2) chk("prerst_off", 16'(cache_word_offset), 16'(c - 2));
            tick();
        end
        drive(1'b0, 16'h0000, 1'b1);
        chk("prerst_busy", 16'(fsm_busy), 16'd1);
        rst = 1'b1;
        #1;
        chk_idle("midrst", 16'h0000);
        chk("midrst_off", 16'(cache_word_offset), 16'd0);
        @(negedge clk);
        rst = 1'b0;
        memory_data_valid = 1'b0;
        tick();
        drive(1'b1, 16'h0010, 1'b0);
        chk("fresh_m_busy", 16'(fsm_busy), 16'd1);
        tick();
        run_fill("fresh", 16'h0010, 3, 1, 1'b0);
        drive(1'b0, 16'h0000, 1'b0);
        chk_idle("fresh_end", 16'h001E);

        // Spurious valids in IDLE
        tick();
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 16'h0000, 1'b1);
            chk_idle("spur", 16'h001E);
            tick();
        end
        drive(1'b0, 16'h0000, 1'b0);
        chk_idle("spur_after", 16'h001E);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
